disp_scan_reader: RTL and testbench
===================================

// Module: disp_scan_reader
// PURPOSE
// - Read side of the 1-bpp frame-buffer RAM (1-clk registered read, 2**17 addresses).
// - Generates raster timing, drives sequential read addresses and absorbs RAM read latency.
// - Emits pixel, sync and data-enable outputs, aligned to each other, to the display pins.
// PARAMETERS
// - ADDR_W    17   frame-buffer address width
// - H_ACTIVE  320  visible pixels per line
// - H_FP      8    horizontal front porch, pixels
// - H_SYNC    48   hsync width, pixels
// - H_BP      24   horizontal back porch, pixels (line total 400)
// - V_ACTIVE  240  visible lines per frame
// - V_FP      3    vertical front porch, lines
// - V_SYNC    4    vsync width, lines
// - V_BP      15   vertical back porch, lines (frame total 262)
// PORTS
// - clk          in   1       single system clock, rising edge
// - rst          in   1       asynchronous reset, active-high
// - pix_en       in   1       pixel-rate strobe; raster advances only on clk with pix_en=1
// - rd_addr      out  ADDR_W  frame-buffer read address, registered
// - rd_data      in   1       RAM read data, valid 1 clk after rd_addr
// - pix_out      out  1       pixel to display, 0 whenever de=0
// - de           out  1       data enable, high in active region
// - hsync        out  1       active-low horizontal sync
// - vsync        out  1       active-low vertical sync
// - frame_start  out  1       1-clk pulse with first output clk of pixel (0,0)
// BEHAVIOUR
// - Reset (async): h_cnt=0, v_cnt=0, rd_addr=0, pipeline cleared.
// - Reset output values: pix_out=0, de=0, hsync=1, vsync=1, frame_start=0.
// - Reset mid-frame: immediate clear; raster restarts at (0,0) on release; no frame_start for that frame.
// - Counters on pix_en: h_cnt 0..H_total-1, wraps to 0 and increments v_cnt; v_cnt 0..V_total-1, wraps to 0.
// - Active region: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
// - hsync low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
// - vsync low on the same rule applied to v_cnt with V_ACTIVE, V_FP, V_SYNC.
// - rd_addr updates on the same edge as the counters.
// - rd_addr increments by 1 per active pixel; holds during blanking; returns to 0 on v_cnt wrap.
// - rd_addr range is 0..H_ACTIVE*V_ACTIVE-1 (76799 at defaults); no multiplier used.
// - Elaboration error if H_ACTIVE*V_ACTIVE > 2**ADDR_W.
// - Pipeline: stage 1 = RAM register; stage 2 = output register.
// - de, hsync, vsync and frame flags are delayed 2 clk so they stay aligned with rd_data.
// - Total latency: 2 clk from counter/rd_addr update to all outputs. Independent of pix_en rate.
// - pix_out = rd_data & de_delayed.
// - frame_start is asserted on the first clk only, even if pix_en is sparse.
// - Simultaneous h and v wrap on the same pix_en: single transition to (0,0); rd_addr=0.
// CONFIGURATION
// - TEST_PATTERN_EN defined: adds input test_pat (1 bit).
//   - When test_pat=1: pix_out = (x[3]^y[3]) & de, i.e. an 8x8 checkerboard.
//   - x and y are the 2-clk-delayed h_cnt and v_cnt.
//   - rd_addr sequencing is unchanged.
// - TEST_PATTERN_EN undefined: no test_pat port; pix_out always comes from rd_data.
// TESTING
// - Reset: rst=1 mid-line, then released, pix_en=1.
//   -> outputs at reset values at once; rd_addr=0; de=1 on the 2nd clk after release.
// - Data path: RAM model ram[a]=a[0], pix_en=1.
//   -> pix_out per line = 0,1,0,1...; 320 clk with de=1, then de=0 and pix_out=0 for 80 clk.
// - Line timing: pix_en=1.
//   -> hsync low 48 clk beginning 330 clk after line start (h=328 + 2 latency); line period 400 clk.
// - Frame timing:
//   -> vsync low during lines 243..246; frame_start exactly once per 104800 clk.
//   -> rd_addr hits 76799, holds through blanking, then 0.
// - Slow strobe: pix_en=1 every 3rd clk.
//   -> line period 1200 clk; each pixel held 3 clk; frame_start still 1 clk wide.
// - TEST_PATTERN_EN, test_pat=1:
//   -> pix_out toggles every 8 active pixels; phase inverts every 8 lines.

Source files
------------

// File: rtl/disp_scan_reader_if.sv
// Display scan-reader bus: pixel strobe, frame-buffer read port and display pins.
// Optional TEST_PATTERN_EN build adds the test_pat select line.
interface disp_scan_reader_if #(
  parameter int ADDR_W = 17
);
  logic              pix_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              pix_out;
  logic              de;
  logic              hsync;
  logic              vsync;
  logic              frame_start;
`ifdef TEST_PATTERN_EN
  logic              test_pat;

  modport master (
    input  pix_en, rd_data, test_pat,
    output rd_addr, pix_out, de, hsync, vsync, frame_start
  );

  modport slave (
    output pix_en, rd_data, test_pat,
    input  rd_addr, pix_out, de, hsync, vsync, frame_start
  );
`else
  modport master (
    input  pix_en, rd_data,
    output rd_addr, pix_out, de, hsync, vsync, frame_start
  );

  modport slave (
    output pix_en, rd_data,
    input  rd_addr, pix_out, de, hsync, vsync, frame_start
  );
`endif
endinterface

// File: rtl/disp_scan_reader.sv
// Read side of a 1-bpp frame buffer: raster timing, sequential read addresses,
// and a two-stage pipeline that lines up sync/enable with the RAM read data.
// Macro TEST_PATTERN_EN adds a test_pat input selecting an 8x8 checkerboard.
module disp_scan_reader #(
  parameter int ADDR_W   = 17,
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 24,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 15
) (
  input  logic               clk,
  input  logic               rst,
  disp_scan_reader_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);

  // The visible area must fit in the frame-buffer address space.
  if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_size_chk
    $error("disp_scan_reader: H_ACTIVE*V_ACTIVE exceeds 2**ADDR_W");
  end

  // The checkerboard uses bit 3 of both counters.
  if (H_W < 4 || V_W < 4) begin : g_cnt_chk
    $error("disp_scan_reader: raster totals must be at least 9");
  end

  // Raster position and read address (the counter stage).
  logic [H_W-1:0]    h_cnt;
  logic [V_W-1:0]    v_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              frame_p0;

  // Next-position decode.
  logic [H_W-1:0]    h_nxt;
  logic [V_W-1:0]    v_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              h_wrap;
  logic              v_wrap;
  logic              nxt_active;
  logic              cur_active;
  logic              cur_hs;
  logic              cur_vs;

  // Stage 1 (alongside the RAM register) and stage 2 (output register).
  logic de_p1;
  logic hs_p1;
  logic vs_p1;
  logic frame_p1;
  logic pix_src;
  logic pix_p2;
  logic de_p2;
  logic hs_p2;
  logic vs_p2;
  logic frame_p2;
`ifdef TEST_PATTERN_EN
  logic chk_p1;
`endif

  // Next raster position, next read address, and decode of the current position.
  always_comb begin
    h_wrap     = (h_cnt == H_LAST);
    v_wrap     = h_wrap && (v_cnt == V_LAST);
    h_nxt      = h_wrap ? '0 : h_cnt + H_W'(1);
    v_nxt      = v_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v_cnt + V_W'(1);
    end
    nxt_active = (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
    // Address tracks the current pixel: it steps only when moving onto an
    // active pixel, so it parks on the last active address during blanking.
    if (v_wrap) begin
      addr_nxt = '0;
    end else if (nxt_active) begin
      addr_nxt = rd_addr + ADDR_W'(1);
    end else begin
      addr_nxt = rd_addr;
    end
    cur_active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    cur_hs     = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    cur_vs     = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
  end

  // ---- counter stage: raster counters and read address advance on pix_en ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      rd_addr  <= '0;
      frame_p0 <= 1'b0;
    end else begin
      // Only a wrap into (0,0) marks a frame; one clk wide regardless of strobe rate.
      frame_p0 <= bus.pix_en && v_wrap;
      if (bus.pix_en) begin
        h_cnt   <= h_nxt;
        v_cnt   <= v_nxt;
        rd_addr <= addr_nxt;
      end
    end
  end

  // ---- stage 1: timing flags wait while the RAM registers its read ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_p1    <= 1'b0;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
      frame_p1 <= 1'b0;
`ifdef TEST_PATTERN_EN
      chk_p1   <= 1'b0;
`endif
    end else begin
      de_p1    <= cur_active;
      hs_p1    <= cur_hs;
      vs_p1    <= cur_vs;
      frame_p1 <= frame_p0;
`ifdef TEST_PATTERN_EN
      chk_p1   <= h_cnt[3] ^ v_cnt[3];
`endif
    end
  end

  // Pixel source selection ahead of the output register.
  always_comb begin
`ifdef TEST_PATTERN_EN
    pix_src = bus.test_pat ? chk_p1 : bus.rd_data;
`else
    pix_src = bus.rd_data;
`endif
  end

  // ---- stage 2: output register, pixel gated by the aligned data enable ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_p2   <= 1'b0;
      de_p2    <= 1'b0;
      hs_p2    <= 1'b1;
      vs_p2    <= 1'b1;
      frame_p2 <= 1'b0;
    end else begin
      pix_p2   <= pix_src & de_p1;
      de_p2    <= de_p1;
      hs_p2    <= hs_p1;
      vs_p2    <= vs_p1;
      frame_p2 <= frame_p1;
    end
  end

  assign bus.rd_addr     = rd_addr;
  assign bus.pix_out     = pix_p2;
  assign bus.de          = de_p2;
  assign bus.hsync       = hs_p2;
  assign bus.vsync       = vs_p2;
  assign bus.frame_start = frame_p2;

endmodule

// File: tb/tb_disp_scan_reader.sv
// Bench for disp_scan_reader on a reduced raster (24x15 total, 16x10 visible)
// so whole frames fit in a short run.
module tb_disp_scan_reader;

  localparam int AW = 8;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 10, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  disp_scan_reader_if #(.ADDR_W(AW)) bus ();

  disp_scan_reader #(
    .ADDR_W(AW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Frame-buffer RAM with one-clock registered read.
  bit ram [0:(1<<AW)-1];
  always @(posedge clk) bus.rd_data <= ram[bus.rd_addr];

  int vectors = 0;
  int miscompares = 0;
  int fs_seen = 0;
  int max_addr = 0;
  bit tp = 1'b0;

  // Reference model: raster position after each clock edge, kept 3 deep.
  typedef struct {
    bit valid;
    int h;
    int v;
    bit wr;
  } pos_t;
  pos_t hist [3];
  int mh, mv;

  typedef struct {
    bit rst;
    bit pen;
    bit pix;
    bit de;
    bit hs;
    bit vs;
    bit fs;
    int addr;
  } vec_t;
  vec_t tbl [8];

  function automatic int m_addr(int h, int v);
    if (v >= VA) return VA * HA - 1;
    if (h >= HA) return v * HA + HA - 1;
    return v * HA + h;
  endfunction

  function automatic logic [AW+4:0] model_out();
    bit pix, de, hs, vs, fs;
    pos_t p;
    p = hist[2];
    if (!p.valid) begin
      pix = 0; de = 0; hs = 1; vs = 1; fs = 0;
    end else begin
      de = (p.h < HA) && (p.v < VA);
      hs = !((p.h >= HA + HF) && (p.h < HA + HF + HS));
      vs = !((p.v >= VA + VF) && (p.v < VA + VF + VS));
      fs = p.wr;
      if (tp) pix = ((p.h / 8) % 2 != (p.v / 8) % 2) && de;
      else    pix = ram[m_addr(p.h, p.v)] && de;
    end
    return {pix, de, hs, vs, fs, AW'(m_addr(hist[0].h, hist[0].v))};
  endfunction

  function automatic logic [AW+4:0] dut_out();
    return {bus.pix_out, bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.rd_addr};
  endfunction

  task automatic compare(input string name, input logic [AW+4:0] act, input logic [AW+4:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @%0t: got {pix,de,hs,vs,fs,addr}=%h want %h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    mh = 0;
    mv = 0;
    hist[0] = '{1'b1, 0, 0, 1'b0};
    hist[1] = '{1'b0, 0, 0, 1'b0};
    hist[2] = '{1'b0, 0, 0, 1'b0};
  endtask

  // One clock: drive strobe, advance the model at the edge, compare at the falling edge.
  task automatic step(input bit pen, input string name);
    bit wr;
    bus.pix_en = pen;
    @(posedge clk);
    if (!rst) begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      wr = 1'b0;
      if (pen) begin
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv++;
          if (mv == VT) mv = 0;
        end
        wr = (mh == 0) && (mv == 0);
      end
      hist[0] = '{1'b1, mh, mv, wr};
    end
    @(negedge clk);
    compare(name, dut_out(), model_out());
    if (bus.frame_start) fs_seen++;
    if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
  endtask

  initial begin
    bus.pix_en = 1'b0;
`ifdef TEST_PATTERN_EN
    bus.test_pat = 1'b0;
`endif
    for (int a = 0; a < (1 << AW); a++) ram[a] = a[0];

    // Reset release and first pixels, including one idle strobe.
    //            rst   pen   pix   de    hs    vs    fs    addr
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst;
      bus.pix_en = tbl[i].pen;
      @(posedge clk);
      @(negedge clk);
      compare($sformatf("table[%0d]", i), dut_out(),
              {tbl[i].pix, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs, AW'(tbl[i].addr)});
    end

    // Two full frames at full pixel rate.
    rst = 1'b1;
    model_reset();
    step(1'b1, "reset_hold");
    rst = 1'b0;
    fs_seen = 0;
    for (int i = 0; i < 2 * HT * VT + 50; i++) step(1'b1, "full_rate");
    compare("frame_count_full", {5'b0, AW'(fs_seen)}, {5'b0, AW'(2)});

    // Asynchronous reset in the middle of a line.
    #2 rst = 1'b1;
    #1 compare("async_reset", dut_out(), {5'b00110, AW'(0)});
    model_reset();
    step(1'b1, "reset_hold2");
    rst = 1'b0;

    // Slow strobe: one pixel every third clock for just over a frame.
    fs_seen = 0;
    for (int i = 0; i < 3 * HT * VT + 20; i++) step((i % 3) == 0, "slow_strobe");
    compare("frame_count_slow", {5'b0, AW'(fs_seen)}, {5'b0, AW'(1)});

    // Random RAM contents and random strobe.
    rst = 1'b1;
    for (int a = 0; a < (1 << AW); a++) ram[a] = 1'($urandom_range(0, 1));
    model_reset();
    step(1'b1, "reset_hold3");
    rst = 1'b0;
    max_addr = 0;
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 2) != 0, "random");
    compare("max_addr", {5'b0, AW'(max_addr)}, {5'b0, AW'(HA * VA - 1)});

`ifdef TEST_PATTERN_EN
    tp = 1'b1;
    bus.test_pat = 1'b1;
    for (int i = 0; i < HT * VT + 30; i++) step(1'b1, "test_pattern");
    tp = 1'b0;
    bus.test_pat = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, "test_pattern_off");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
